ctrl_pipe: RTL

//  Decode-once control pipeline for the 5-stage MIPS core. Decodes the D-stage instruction (add sub sll jr ori lw sw beq lui jal),

---
 rtl/ctrl_pipe.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe.sv
// Decode-once control pipeline: decodes D once, carries write-back control
// through NSTG stages and derives the Tuse/Tnew stall for D.
module ctrl_pipe #(
    parameter int NSTG   = 3,
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instr_d,
    input  logic                     hold,
    output logic                     stall,
    output logic [NSTG-1:0]          stg_wr,
    output logic [NSTG*ADDR_W-1:0]   stg_addr,
    output logic [NSTG*TNEW_W-1:0]   stg_tnew,
    output logic [NSTG-1:0]          stg_ready,
    output logic                     w_reg_write,
    output logic [ADDR_W-1:0]        w_reg_addr,
    output logic [2:0]               w_data_op
);

    logic [5:0] opc;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign opc          = instr_d[31:26];
    assign rs           = instr_d[25:21];
    assign rt           = instr_d[20:16];
    assign rd           = instr_d[15:11];
    assign fn           = instr_d[5:0];
    assign unused_shamt = ^instr_d[10:6];

    logic is_r;
    logic is_add, is_sub, is_sll, is_jr;
    logic is_ori, is_lw, is_sw, is_beq, is_lui, is_jal;

    assign is_r   = (opc == 6'b000000);
    assign is_add = is_r && (fn == 6'b100000);
    assign is_sub = is_r && (fn == 6'b100010);
    assign is_sll = is_r && (fn == 6'b000000);
    assign is_jr  = is_r && (fn == 6'b001000);
    assign is_ori = (opc == 6'b001101);
    assign is_lw  = (opc == 6'b100011);
    assign is_sw  = (opc == 6'b101011);
    assign is_beq = (opc == 6'b000100);
    assign is_lui = (opc == 6'b001111);
    assign is_jal = (opc == 6'b000011);

    logic [4:0]        dec_dst;
    logic              dec_wr;
    logic [2:0]        dec_op;
    logic [TNEW_W-1:0] dec_tnew;
    logic              use_rs;
    logic              use_rt;
    logic [TNEW_W-1:0] tuse_rs;
    logic [TNEW_W-1:0] tuse_rt;

    // Decode the D instruction into write-back control and source Tuse.
    always_comb begin
        dec_dst  = '0;
        dec_op   = 3'd0;
        dec_tnew = '0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        tuse_rs  = '0;
        tuse_rt  = '0;
        unique case (1'b1)
            is_add, is_sub: begin
                dec_dst  = rd;
                dec_tnew = TNEW_W'(1);
                use_rs   = 1'b1;
                tuse_rs  = TNEW_W'(1);
                use_rt   = 1'b1;
                tuse_rt  = TNEW_W'(1);
            end
            is_sll: begin
                dec_dst  = rd;
                dec_tnew = TNEW_W'(1);
                use_rt   = 1'b1;
                tuse_rt  = TNEW_W'(1);
            end
            is_jr: begin
                use_rs  = 1'b1;
                tuse_rs = TNEW_W'(0);
            end
            is_ori: begin
                dec_dst  = rt;
                dec_tnew = TNEW_W'(1);
                use_rs   = 1'b1;
                tuse_rs  = TNEW_W'(1);
            end
            is_lw: begin
                dec_dst  = rt;
                dec_tnew = TNEW_W'(2);
                dec_op   = 3'd1;
                use_rs   = 1'b1;
                tuse_rs  = TNEW_W'(1);
            end
            is_sw: begin
                use_rs  = 1'b1;
                tuse_rs = TNEW_W'(1);
                use_rt  = 1'b1;
                tuse_rt = TNEW_W'(2);
            end
            is_beq: begin
                use_rs  = 1'b1;
                tuse_rs = TNEW_W'(0);
                use_rt  = 1'b1;
                tuse_rt = TNEW_W'(0);
            end
            is_lui: begin
                dec_dst  = rt;
                dec_tnew = TNEW_W'(1);
                dec_op   = 3'd2;
            end
            is_jal: begin
                dec_dst  = 5'd31;
                dec_tnew = TNEW_W'(0);
                dec_op   = 3'd3;
            end
            default: begin
            end
        endcase
        dec_wr = (dec_dst != 5'd0);
    end

    logic [NSTG-1:0]   wr_q,   wr_d;
    logic [ADDR_W-1:0] addr_q [NSTG];
    logic [ADDR_W-1:0] addr_d [NSTG];
    logic [TNEW_W-1:0] tnew_q [NSTG];
    logic [TNEW_W-1:0] tnew_d [NSTG];
    logic [2:0]        op_q   [NSTG];
    logic [2:0]        op_d   [NSTG];

    // Stall when an in-flight writer of a used source produces too late.
    always_comb begin
        stall = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            if (wr_q[k]) begin
                if (use_rs && rs != 5'd0 &&
                    addr_q[k] == ADDR_W'(rs) &&
                    tnew_q[k] > tuse_rs)
                    stall = 1'b1;
                if (use_rt && rt != 5'd0 &&
                    addr_q[k] == ADDR_W'(rt) &&
                    tnew_q[k] > tuse_rt)
                    stall = 1'b1;
            end
        end
    end

    // Shift entries one stage, aging Tnew; bubble into E on stall.
    always_comb begin
        wr_d = wr_q;
        for (int k = 0; k < NSTG; k++) begin
            addr_d[k] = addr_q[k];
            tnew_d[k] = tnew_q[k];
            op_d[k]   = op_q[k];
        end
        if (!hold) begin
            if (stall) begin
                wr_d[0]   = 1'b0;
                addr_d[0] = '0;
                tnew_d[0] = '0;
                op_d[0]   = 3'd0;
            end else begin
                wr_d[0]   = dec_wr;
                addr_d[0] = ADDR_W'(dec_dst);
                tnew_d[0] = dec_tnew;
                op_d[0]   = dec_op;
            end
            for (int k = 1; k < NSTG; k++) begin
                wr_d[k]   = wr_q[k-1];
                addr_d[k] = addr_q[k-1];
                op_d[k]   = op_q[k-1];
                tnew_d[k] = (tnew_q[k-1] == '0) ? '0
                          : tnew_q[k-1] - TNEW_W'(1);
            end
        end
    end

    // Stage registers with synchronous reset to bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            for (int k = 0; k < NSTG; k++) begin
                addr_q[k] <= '0;
                tnew_q[k] <= '0;
                op_q[k]   <= 3'd0;
            end
        end else begin
            wr_q <= wr_d;
            for (int k = 0; k < NSTG; k++) begin
                addr_q[k] <= addr_d[k];
                tnew_q[k] <= tnew_d[k];
                op_q[k]   <= op_d[k];
            end
        end
    end

    // Flatten per-stage state onto the output buses.
    always_comb begin
        stg_addr  = '0;
        stg_tnew  = '0;
        stg_ready = '0;
        for (int k = 0; k < NSTG; k++) begin
            stg_addr[k*ADDR_W +: ADDR_W] = addr_q[k];
            stg_tnew[k*TNEW_W +: TNEW_W] = tnew_q[k];
            stg_ready[k] = wr_q[k] && (tnew_q[k] == '0);
        end
    end

    assign stg_wr      = wr_q;
    assign w_reg_write = wr_q[NSTG-1];
    assign w_reg_addr  = addr_q[NSTG-1];
    assign w_data_op   = op_q[NSTG-1];

endmodule
